// File: rtl/morse_key_decoder.sv
// Morse key receiver: synchronises and debounces a raw key, times marks/spaces in ticks,
// and emits one dot/dash code word per letter. Define MORSE_WORD_GAP_EN for word-gap pulses.
module morse_key_decoder #(
    parameter int TICK_DIV         = 100000,
    parameter int DEBOUNCE_TICKS   = 20,
    parameter int DASH_TICKS       = 300,
    parameter int LETTER_GAP_TICKS = 600,
    parameter int WORD_GAP_TICKS   = 1400,
    parameter int MAX_SYMS         = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_in,
    output logic                key_level,
    output logic [MAX_SYMS-1:0] sym_code,
    output logic [2:0]          sym_len,
    output logic                sym_valid,
    output logic                overflow,
    output logic                word_space
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_WORD_WAIT
    } state_t;

    logic [1:0]          sync_q;
    logic                key_sync;
    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic [DW-1:0]       db_cnt_q, db_cnt_d;
    logic                level_q, level_d;
    logic                key_rise, key_fall;

    state_t              state_q, state_d;
    logic [15:0]         mark_cnt_q, mark_cnt_d, mark_inc;
    logic [15:0]         gap_cnt_q, gap_cnt_d, gap_inc;
    logic                sym_dash;
    logic [MAX_SYMS-1:0] acc_code_q, acc_code_d;
    logic [2:0]          acc_len_q, acc_len_d;
    logic                acc_ovf_q, acc_ovf_d;
    logic [MAX_SYMS-1:0] sym_code_q, sym_code_d;
    logic [2:0]          sym_len_q, sym_len_d;
    logic                ovf_q, ovf_d;
    logic                sym_valid_q, sym_valid_d;
`ifdef MORSE_WORD_GAP_EN
    logic                word_space_q, word_space_d;
`endif

    assign key_sync = sync_q[1];
    assign tick     = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d  = tick ? '0 : presc_q + PW'(1);

    // Level only moves on a tick, so rise/fall are single-cycle, tick-aligned events.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        key_rise = 1'b0;
        key_fall = 1'b0;
        if (tick) begin
            if (key_sync != level_q) begin
                if (db_cnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
                    level_d  = ~level_q;
                    db_cnt_d = '0;
                    key_rise = ~level_q;
                    key_fall = level_q;
                end else begin
                    db_cnt_d = db_cnt_q + DW'(1);
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    assign mark_inc = (&mark_cnt_q) ? mark_cnt_q : mark_cnt_q + 16'd1;
    assign gap_inc  = (&gap_cnt_q) ? gap_cnt_q : gap_cnt_q + 16'd1;
    // Mark length includes the tick on which the release is seen.
    assign sym_dash = (mark_inc >= 16'(DASH_TICKS));

    always_comb begin
        state_d     = state_q;
        mark_cnt_d  = mark_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        acc_code_d  = acc_code_q;
        acc_len_d   = acc_len_q;
        acc_ovf_d   = acc_ovf_q;
        sym_code_d  = sym_code_q;
        sym_len_d   = sym_len_q;
        ovf_d       = ovf_q;
        sym_valid_d = 1'b0;
`ifdef MORSE_WORD_GAP_EN
        word_space_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_rise) begin
                    state_d    = ST_MARK;
                    mark_cnt_d = '0;
                end
            end
            ST_MARK: begin
                if (tick) begin
                    mark_cnt_d = mark_inc;
                    if (key_fall) begin
                        if (acc_len_q < 3'(MAX_SYMS)) begin
                            for (int i = 0; i < MAX_SYMS; i++) begin
                                if (acc_len_q == 3'(i)) acc_code_d[i] = sym_dash;
                            end
                            acc_len_d = acc_len_q + 3'd1;
                        end else begin
                            acc_ovf_d = 1'b1;
                        end
                        gap_cnt_d = '0;
                        state_d   = ST_SPACE;
                    end
                end
            end
            ST_SPACE: begin
                if (tick) begin
                    gap_cnt_d = gap_inc;
                    if (gap_inc >= 16'(LETTER_GAP_TICKS)) begin
                        sym_code_d  = acc_code_q;
                        sym_len_d   = acc_len_q;
                        ovf_d       = acc_ovf_q;
                        sym_valid_d = 1'b1;
                        acc_code_d  = '0;
                        acc_len_d   = '0;
                        acc_ovf_d   = 1'b0;
                        // A press landing on the closing tick starts the next letter.
                        if (key_rise) begin
                            state_d    = ST_MARK;
                            mark_cnt_d = '0;
                        end else begin
`ifdef MORSE_WORD_GAP_EN
                            state_d = ST_WORD_WAIT;
`else
                            state_d = ST_IDLE;
`endif
                        end
                    end else if (key_rise) begin
                        state_d    = ST_MARK;
                        mark_cnt_d = '0;
                    end
                end
            end
`ifdef MORSE_WORD_GAP_EN
            ST_WORD_WAIT: begin
                if (tick) begin
                    gap_cnt_d = gap_inc;
                    if (key_rise) begin
                        state_d    = ST_MARK;
                        mark_cnt_d = '0;
                    end else if (gap_inc >= 16'(WORD_GAP_TICKS)) begin
                        word_space_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            presc_q     <= '0;
            db_cnt_q    <= '0;
            level_q     <= 1'b0;
            state_q     <= ST_IDLE;
            mark_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            acc_code_q  <= '0;
            acc_len_q   <= '0;
            acc_ovf_q   <= 1'b0;
            sym_code_q  <= '0;
            sym_len_q   <= '0;
            ovf_q       <= 1'b0;
            sym_valid_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_in};
            presc_q     <= presc_d;
            db_cnt_q    <= db_cnt_d;
            level_q     <= level_d;
            state_q     <= state_d;
            mark_cnt_q  <= mark_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            acc_code_q  <= acc_code_d;
            acc_len_q   <= acc_len_d;
            acc_ovf_q   <= acc_ovf_d;
            sym_code_q  <= sym_code_d;
            sym_len_q   <= sym_len_d;
            ovf_q       <= ovf_d;
            sym_valid_q <= sym_valid_d;
        end
    end

`ifdef MORSE_WORD_GAP_EN
    always_ff @(posedge clk) begin
        if (rst) word_space_q <= 1'b0;
        else     word_space_q <= word_space_d;
    end
    assign word_space = word_space_q;
`else
    assign word_space = 1'b0;
`endif

    assign key_level = level_q;
    assign sym_code  = sym_code_q;
    assign sym_len   = sym_len_q;
    assign overflow  = ovf_q;
    assign sym_valid = sym_valid_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder; key changes are aligned to tick boundaries.
module tb_morse_key_decoder;

    localparam int TICK_DIV         = 4;
    localparam int DEBOUNCE_TICKS   = 2;
    localparam int DASH_TICKS       = 6;
    localparam int LETTER_GAP_TICKS = 10;
    localparam int WORD_GAP_TICKS   = 20;
    localparam int MAX_SYMS         = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                key_in = 1'b0;
    logic                key_level;
    logic [MAX_SYMS-1:0] sym_code;
    logic [2:0]          sym_len;
    logic                sym_valid;
    logic                overflow;
    logic                word_space;

    morse_key_decoder #(
        .TICK_DIV        (TICK_DIV),
        .DEBOUNCE_TICKS  (DEBOUNCE_TICKS),
        .DASH_TICKS      (DASH_TICKS),
        .LETTER_GAP_TICKS(LETTER_GAP_TICKS),
        .WORD_GAP_TICKS  (WORD_GAP_TICKS),
        .MAX_SYMS        (MAX_SYMS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_level (key_level),
        .sym_code  (sym_code),
        .sym_len   (sym_len),
        .sym_valid (sym_valid),
        .overflow  (overflow),
        .word_space(word_space)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    int n_valid = 0;
    int n_word  = 0;
    int n_lvl   = 0;
    int cap_code = 0;
    int cap_len  = 0;
    int cap_ovf  = 0;
    int cap_cyc  = 0;
    int ws_cyc   = 0;
    always @(negedge clk) begin
        if (sym_valid) begin
            n_valid  <= n_valid + 1;
            cap_code <= int'(sym_code);
            cap_len  <= int'(sym_len);
            cap_ovf  <= int'(overflow);
            cap_cyc  <= cyc;
        end
        if (word_space) begin
            n_word <= n_word + 1;
            ws_cyc <= cyc;
        end
        if (key_level) n_lvl <= n_lvl + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int rel_cyc  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * TICK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic press(input int on_t, input int off_t);
        key_in = 1'b1;
        ticks(on_t);
        key_in = 1'b0;
        rel_cyc = cyc;
        ticks(off_t);
    endtask

    task automatic pulse_rst(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic letter_check(input string name, input int base_v, input int exp_n,
                                input int exp_code, input int exp_len, input int exp_ovf);
        $display("txn %s: letters=%0d code=%b len=%0d ovf=%0d", name, n_valid - base_v,
                 cap_code[MAX_SYMS-1:0], cap_len, cap_ovf);
        check_eq({name, ".count"}, n_valid - base_v, exp_n);
        check_eq({name, ".code"}, cap_code, exp_code);
        check_eq({name, ".len"}, cap_len, exp_len);
        check_eq({name, ".ovf"}, cap_ovf, exp_ovf);
    endtask

    int bv, bl, bw;

    initial begin
        pulse_rst(3);
        $display("txn reset: level=%0d code=%b len=%0d valid=%0d ovf=%0d ws=%0d",
                 key_level, sym_code, sym_len, sym_valid, overflow, word_space);
        check_eq("rst.key_level", key_level, 0);
        check_eq("rst.sym_code", sym_code, 0);
        check_eq("rst.sym_len", sym_len, 0);
        check_eq("rst.sym_valid", sym_valid, 0);
        check_eq("rst.overflow", overflow, 0);
        check_eq("rst.word_space", word_space, 0);

        // Letter A: dot then dash.
        bv = n_valid; bl = n_lvl;
        press(3, 3);
        press(8, 12);
        ticks(2);
        letter_check("A", bv, 1, 2, 2, 0);
        check_eq("A.latency", cap_cyc - rel_cyc, 48);
        check_eq("A.level_cycles", n_lvl - bl, 44);

        // One-tick glitch must be filtered out completely.
        bv = n_valid; bl = n_lvl;
        press(1, 30);
        $display("txn glitch: letters=%0d level_cycles=%0d", n_valid - bv, n_lvl - bl);
        check_eq("glitch.count", n_valid - bv, 0);
        check_eq("glitch.level_cycles", n_lvl - bl, 0);

        // Seven dots: only six kept, overflow flagged.
        bv = n_valid;
        for (int i = 0; i < 6; i++) press(3, 3);
        press(3, 12);
        ticks(2);
        letter_check("ovf", bv, 1, 0, 6, 1);

        // Reset during SPACE discards the pending dash.
        bv = n_valid;
        press(8, 3);
        pulse_rst(1);
        check_eq("midrst.sym_len", sym_len, 0);
        check_eq("midrst.overflow", overflow, 0);
        press(3, 12);
        ticks(2);
        letter_check("midrst_E", bv, 1, 0, 1, 0);

        // Dash threshold and letter-gap boundaries.
        bv = n_valid;
        press(6, 12);
        ticks(1);
        letter_check("mark6", bv, 1, 1, 1, 0);
        bv = n_valid;
        press(5, 12);
        ticks(1);
        letter_check("mark5", bv, 1, 0, 1, 0);
        bv = n_valid;
        press(3, 9);
        press(3, 12);
        ticks(1);
        letter_check("gap9", bv, 1, 0, 2, 0);
        bv = n_valid;
        press(3, 10);
        press(6, 12);
        ticks(1);
        letter_check("gap10", bv, 2, 1, 1, 0);

        // Word gap after a single letter.
        bv = n_valid; bw = n_word;
        press(3, 25);
        ticks(2);
        letter_check("word_E", bv, 1, 0, 1, 0);
        $display("txn word: pulses=%0d", n_word - bw);
`ifdef MORSE_WORD_GAP_EN
        check_eq("word.count", n_word - bw, 1);
        check_eq("word.delay", ws_cyc - cap_cyc, 40);
`else
        check_eq("word.count", n_word - bw, 0);
        check_eq("word.total", n_word, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Receive-side counterpart of the buzzer output path: samples a raw Morse key/button and decodes timed presses into dot/dash letter codes.
- Handles synchronisation, debounce, mark/space timing and letter framing.
- Outputs one code word per letter to the downstream character lookup and display logic.

Parameters:
TICK_DIV, 100000, clk cycles per timing tick (1 ms at 100 MHz)
DEBOUNCE_TICKS, 20, consecutive ticks key must differ from debounced level before the level flips
DASH_TICKS, 300, mark length in ticks at or above which a press is a dash
LETTER_GAP_TICKS, 600, space length in ticks that closes a letter
WORD_GAP_TICKS, 1400, space length in ticks that flags a word break (optional feature only)
MAX_SYMS, 6, maximum symbols per letter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
key_in  input  1  raw asynchronous key, 1 = pressed
key_level  output  1  debounced key level
sym_code  output  MAX_SYMS  bit i = symbol i (first symbol at bit 0), 1 = dash, 0 = dot; unused bits 0
sym_len  output  3  number of symbols in sym_code, 0..MAX_SYMS
sym_valid  output  1  one-cycle pulse; sym_code/sym_len/overflow valid
overflow  output  1  letter had more than MAX_SYMS presses; extra symbols dropped
word_space  output  1  one-cycle pulse on word gap (optional feature only, else tied 0)

Behaviour:
- Reset: sync regs, all counters, and the accumulator are cleared; state is IDLE; every output is 0.
- Reset mid-letter: partial letter discarded, no sym_valid.
- Synchroniser: key_in passes through a 2-flop synchroniser before any use.
- Tick: prescaler counts 0..TICK_DIV-1; tick is a 1-cycle pulse on wrap. All timing below is in ticks, sampled on tick cycles only.
- Debounce:
  - On each tick: if synced key != key_level, increment db_cnt; otherwise clear it.
  - When db_cnt reaches DEBOUNCE_TICKS, key_level toggles and db_cnt clears.
  - Pulses shorter than DEBOUNCE_TICKS ticks produce no effect.
- Counters: mark_cnt and gap_cnt are 16-bit and saturate at all-ones; they never wrap.
- FSM states: IDLE, MARK, SPACE.
  - IDLE: wait for key_level rising; on rise go to MARK, clear mark_cnt.
  - MARK: mark_cnt += 1 per tick. On key_level falling:
    - symbol = (mark_cnt >= DASH_TICKS).
    - If acc_len < MAX_SYMS: write the symbol to acc_code[acc_len] and increment acc_len. Otherwise set acc_ovf and drop the symbol.
    - Clear gap_cnt and go to SPACE.
  - SPACE: gap_cnt += 1 per tick.
    - On key_level rising before the letter gap: go to MARK, clear mark_cnt; the letter continues.
    - When gap_cnt reaches LETTER_GAP_TICKS:
      - On the next clk edge, sym_code/sym_len/overflow load acc_code/acc_len/acc_ovf and sym_valid pulses for 1 cycle.
      - The accumulator clears and the FSM goes to IDLE.
- Latency: sym_valid occurs exactly 1 clk after the tick on which gap_cnt reaches LETTER_GAP_TICKS.
- Output hold: sym_code/sym_len/overflow hold their values until the next sym_valid.
- Simultaneous events: key rise on the same tick as gap_cnt reaching LETTER_GAP_TICKS closes the letter first, then the FSM enters MARK directly and starts a new letter; no press is lost.
- Debounce edges are single-cycle events and are consumed on the cycle they occur.

Optional Feature:
MORSE_WORD_GAP_EN
- Defined:
  - After a letter closes, the FSM enters a WORD_WAIT state instead of IDLE, and gap_cnt keeps counting.
  - If gap_cnt reaches WORD_GAP_TICKS, word_space pulses 1 cycle, 1 clk after that tick; then go to IDLE.
  - A key rise in WORD_WAIT goes to MARK with no word_space.
  - word_space resets to 0.
- Undefined: no WORD_WAIT state; word_space is constant 0.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, DEBOUNCE_TICKS=2, DASH_TICKS=6, LETTER_GAP_TICKS=10, WORD_GAP_TICKS=20, MAX_SYMS=6.
- Letter "A": press 3 ticks, release 3, press 8, release 12 -> one sym_valid, sym_code=6'b000010, sym_len=2, overflow=0.
- Glitch: key_in high for 1 tick, then low for 30 ticks -> key_level stays 0, no sym_valid.
- Overflow: 7 dots (press 3 / release 3 each), then release 12 -> sym_code=6'b000000, sym_len=6, overflow=1.
- Reset mid-letter: dash, then rst for 1 cycle during SPACE, then letter "E" (press 3, release 12) -> single sym_valid, sym_code=0, sym_len=1; no stale dash.
- Boundary: press exactly 6 ticks -> dash (code bit0=1). Press 5 ticks -> dot. Release gap of 9 ticks between presses -> same letter (sym_len=2).
- MORSE_WORD_GAP_EN: "E", then key released 25 ticks -> sym_valid, then one word_space pulse 10 ticks later. With the macro undefined -> word_space stays 0.
